// File: rtl/pll_band_cal.sv
`default_nettype none
// ============================================================================
// Module   : pll_band_cal
// Brief    : PLL VCO coarse-band SAR calibration with windowed lock detect.
// Revision : 1.0 - initial release
// ============================================================================
module pll_band_cal #(
    parameter int BW       = 4,
    parameter int CW       = 12,
    parameter int WINDOW   = 1024,
    parameter int TARGET   = 1024,
    parameter int SETTLE   = 64,
    parameter int TOL      = 8,
    parameter int LOCK_WIN = 4
) (
    input  logic          CLK,
    input  logic          Reset,
    input  logic          Start,
    input  logic          FB,
    output logic [BW-1:0] Band,
    output logic          PFD_Resetn,
    output logic          Busy,
    output logic          Done,
    output logic          Lock
);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_SETTLE = 3'd1;
    localparam logic [2:0] c_COUNT  = 3'd2;
    localparam logic [2:0] c_DECIDE = 3'd3;
    localparam logic [2:0] c_TRACK  = 3'd4;

    localparam int TMAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int IW   = (BW > 1) ? $clog2(BW) : 1;
    localparam int GW   = $clog2(LOCK_WIN + 1);

    localparam logic [BW-1:0] c_MID         = {1'b1, {(BW-1){1'b0}}};
    localparam logic [TW-1:0] c_SETTLE_LAST = TW'(SETTLE - 1);
    localparam logic [TW-1:0] c_WIN_LAST    = TW'(WINDOW - 1);
    localparam logic [IW-1:0] c_TOP_BIT     = IW'(BW - 1);
    localparam logic [GW-1:0] c_LOCK_WIN    = GW'(LOCK_WIN);

    logic [2:0]    state_q, state_d;
    logic [BW-1:0] band_q, band_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [GW-1:0] good_q, good_d;
    logic          pfd_q, pfd_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          lock_q, lock_d;
    logic          fb_s1_q, fb_s2_q, fb_d1_q;

    logic          w_fb_rise;
    logic [CW-1:0] w_cnt_inc;
    logic [31:0]   w_cnt_ext;
    logic [31:0]   w_inc_ext;
    logic          w_in_tol;
    logic [GW-1:0] w_good_inc;

    assign w_fb_rise  = fb_s2_q & ~fb_d1_q;
    // Saturating count: a window that overflows is treated as all-ones.
    assign w_cnt_inc  = (w_fb_rise && (cnt_q != {CW{1'b1}})) ? cnt_q + 1'b1 : cnt_q;
    assign w_cnt_ext  = {{(32-CW){1'b0}}, cnt_q};
    assign w_inc_ext  = {{(32-CW){1'b0}}, w_cnt_inc};
    assign w_in_tol   = ((w_inc_ext + TOL) >= TARGET) && (w_inc_ext <= (TARGET + TOL));
    assign w_good_inc = (good_q == c_LOCK_WIN) ? good_q : good_q + 1'b1;

    always_comb begin
        state_d = state_q;
        band_d  = band_q;
        idx_d   = idx_q;
        timer_d = timer_q;
        cnt_d   = cnt_q;
        good_d  = good_q;
        pfd_d   = pfd_q;
        busy_d  = busy_q;
        done_d  = done_q;
        lock_d  = lock_q;
        case (state_q)
            c_SETTLE: begin
                if (timer_q == c_SETTLE_LAST) begin
                    state_d = c_COUNT;
                    timer_d = '0;
                    cnt_d   = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            c_COUNT: begin
                cnt_d = w_cnt_inc;
                if (timer_q == c_WIN_LAST) begin
                    state_d = c_DECIDE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            c_DECIDE: begin
                if (w_cnt_ext > TARGET) begin
                    band_d[idx_q] = 1'b0;
                end
                if (idx_q != '0) begin
                    band_d[idx_q - 1'b1] = 1'b1;
                    idx_d   = idx_q - 1'b1;
                    state_d = c_SETTLE;
                end else begin
                    state_d = c_TRACK;
                    pfd_d   = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                end
                timer_d = '0;
            end
            c_TRACK: begin
                cnt_d = w_cnt_inc;
                if (timer_q == c_WIN_LAST) begin
                    timer_d = '0;
                    cnt_d   = '0;
                    if (w_in_tol) begin
                        good_d = w_good_inc;
                        lock_d = (w_good_inc == c_LOCK_WIN);
                    end else begin
                        good_d = '0;
                        lock_d = 1'b0;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: ;
        endcase
        // A start request outranks any tracking activity in the same cycle.
        if (Start && ((state_q == c_IDLE) || (state_q == c_TRACK))) begin
            state_d = c_SETTLE;
            band_d  = c_MID;
            idx_d   = c_TOP_BIT;
            timer_d = '0;
            cnt_d   = '0;
            good_d  = '0;
            pfd_d   = 1'b0;
            busy_d  = 1'b1;
            done_d  = 1'b0;
            lock_d  = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q <= c_IDLE;
            band_q  <= c_MID;
            idx_q   <= c_TOP_BIT;
            timer_q <= '0;
            cnt_q   <= '0;
            good_q  <= '0;
            pfd_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            lock_q  <= 1'b0;
            fb_s1_q <= 1'b0;
            fb_s2_q <= 1'b0;
            fb_d1_q <= 1'b0;
        end else begin
            state_q <= state_d;
            band_q  <= band_d;
            idx_q   <= idx_d;
            timer_q <= timer_d;
            cnt_q   <= cnt_d;
            good_q  <= good_d;
            pfd_q   <= pfd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            lock_q  <= lock_d;
            fb_s1_q <= FB;
            fb_s2_q <= fb_s1_q;
            fb_d1_q <= fb_s2_q;
        end
    end

    assign Band       = band_q;
    assign PFD_Resetn = pfd_q;
    assign Busy       = busy_q;
    assign Done       = done_q;
    assign Lock       = lock_q;

endmodule
`default_nettype wire

// File: doc/pll_band_cal.md
# pll_band_cal

Digital coarse-band calibration and lock-detect controller for the integer-N PLL. It holds the phase-frequency detector in reset and runs a successive-approximation search over the VCO band code, counting divided-feedback edges against the reference clock in fixed windows. After the search it releases the PFD to close the loop. It then monitors frequency error window-by-window to report lock.

## Interface
Parameters:
- BW, 4: band code width.
- CW, 12: edge-counter width.
- WINDOW, 1024: count window length in CLK cycles.
- TARGET, 1024: expected FB edge count per window.
- SETTLE, 64: CLK cycles waited after each band change.
- TOL, 8: allowed |count − TARGET| for a lock window.
- LOCK_WIN, 4: consecutive in-tolerance windows required to assert Lock.

Ports:
- CLK, input, 1: reference clock; all logic on rising edge.
- Reset, input, 1: asynchronous, active-high; clears all state.
- Start, input, 1: calibration request, level-sampled.
- FB, input, 1: divided VCO feedback, asynchronous to CLK; frequency < CLK/2.
- Band, output, BW: VCO coarse band code; higher code means higher frequency.
- PFD_Resetn, output, 1: drives PFD Resetn; 0 holds the PFD cleared.
- Busy, output, 1: calibration search in progress.
- Done, output, 1: search complete, loop closed.
- Lock, output, 1: frequency lock indication.

## Operation
- Clocking and reset: one clock; reset is asynchronous and active-high.
- Reset values: Band = 1 followed by BW−1 zeros (midcode 4'b1000); PFD_Resetn = 0; Busy = 0; Done = 0; Lock = 0. State returns to IDLE. Counters and synchronizers clear to 0.
- FB path: 2-flop synchronizer plus an edge flop. A rising edge is counted on the cycle it is detected. The counter saturates at 2^CW−1 and never wraps.
- States:
  - IDLE: Start = 1 → SETTLE. Band is loaded with the midcode, bit index i = BW−1, Busy = 1, PFD_Resetn = 0.
  - SETTLE: waits SETTLE cycles, then → COUNT with the edge counter cleared.
  - COUNT: counts edges for exactly WINDOW cycles, then → DECIDE.
  - DECIDE (1 cycle):
    - If count > TARGET, clear Band[i]; count = TARGET keeps the bit.
    - If i > 0: set Band[i−1], decrement i, → SETTLE.
    - If i = 0: → TRACK with PFD_Resetn = 1, Busy = 0, Done = 1.
  - TRACK:
    - Runs back-to-back WINDOW-cycle counts with no settle gap.
    - At each window end, if |count − TARGET| ≤ TOL, the good-window counter increments, saturating at LOCK_WIN. Lock = 1 once it reaches LOCK_WIN.
    - Any out-of-tolerance window clears the counter and Lock in the same evaluation cycle.
- Start is honoured in IDLE and TRACK, and ignored in SETTLE, COUNT and DECIDE.
  - In TRACK it restarts calibration: Done = 0, Lock = 0, PFD_Resetn = 0 and Band = midcode, all on the next edge.
- Band changes only on DECIDE and restart edges. It holds its final value through TRACK.
- Reset mid-search aborts immediately to the reset values above; no partial code is retained.

## Timing
- Start high at edge 0: Busy = 1, PFD_Resetn = 0 and Band = midcode at edge 1.
- Each bit takes SETTLE + WINDOW + 1 cycles. TRACK is entered, and Done rises, BW·(SETTLE+WINDOW+1) cycles after edge 1. With the defaults this is 4·1089 = 4356 cycles.
- FB-to-count latency is 3 CLK cycles. Edges arriving within 3 cycles before a window ends are counted in the next window, or dropped if the next state is SETTLE/DECIDE.
- Lock rises on the evaluation edge of the LOCK_WIN-th consecutive good window. Minimum is LOCK_WIN·WINDOW cycles after TRACK entry.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset values: assert Reset mid-COUNT → Band = 1000, PFD_Resetn = 0, Busy/Done/Lock = 0 asynchronously. After release the block stays in IDLE until Start.
- SAR search, with a bench VCO model giving count = 600 + 64·Band:
  - Required codes tried: 1000 (1112, cleared), 0100 (856, kept), 0110 (984, kept), 0111 (1048, cleared).
  - Final Band = 0110; Done and PFD_Resetn rise exactly 4356 cycles after Busy.
- Search extremes:
  - All counts > TARGET → Band = 0000.
  - All counts < TARGET → Band = 1111.
  - Count = TARGET exactly → bit kept.
- Lock: in TRACK, the model gives 1024 per window → Lock rises at the end of window 4. One window at 1040 → Lock falls at that window end. Four further good windows → Lock rises again.
- Restart and ignore:
  - Start pulse during COUNT → no effect; the search completes normally.
  - Start pulse in TRACK with Lock = 1 → next edge Lock = 0, Done = 0, PFD_Resetn = 0, Band = 1000, Busy = 1.
- Saturation: with CW = 8 and count ≥ 256 edges per window, the counter holds at 255 and the DECIDE result treats the window as count = 255.
